// File: rtl/cpu_pkg.sv
// Shared datapath constants and controller state for the CPU register file,
// operand selector and negator.
package cpu_pkg;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned NUM_REGS = 1 << ADDR_W;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } ctrl_state_e;
endpackage

// File: rtl/reg_read_port.sv
// One registered read port of the register file.
// Optional feature macro: REG_FILE_BYPASS_EN (forward same-edge write data).
// Ports:
//   clk, rst_n  clock, async active-low reset
//   i_regs      flattened storage array
//   i_addr      read address
//   i_read      accepted read strobe (already qualified by controller state)
//   i_write     accepted write strobe, i_wr_addr / i_wr_data write side
//   o_data      registered read data (holds when i_read is low)
module reg_read_port
  import cpu_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]    i_regs,
  input  logic [ADDR_W-1:0]                  i_addr,
  input  logic                               i_read,
  input  logic                               i_write,
  input  logic [ADDR_W-1:0]                  i_wr_addr,
  input  logic [DATA_W-1:0]                  i_wr_data,
  output logic [DATA_W-1:0]                  o_data
);

  logic [DATA_W-1:0] w_sel;
  logic [DATA_W-1:0] w_data;
  logic [DATA_W-1:0] r_data;

  assign w_sel = i_regs[i_addr];

`ifdef REG_FILE_BYPASS_EN
  // Same-edge write to the address being read wins over stored contents.
  assign w_data = (i_write && (i_wr_addr == i_addr)) ? i_wr_data : w_sel;
`else
  // Without bypass a same-edge read sees the pre-write contents.
  logic w_unused_byp;
  assign w_unused_byp = ^{i_write, i_wr_addr, i_wr_data};
  assign w_data       = w_sel;
`endif

  // Output register; holds last value when no read is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (i_read) begin
      r_data <= w_data;
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/reg_file.sv
// Eight-entry register file: one write port, two registered read ports,
// post-reset clear sequence that zeroes one register per cycle.
// Optional feature macro: REG_FILE_BYPASS_EN (same-edge write-to-read forward).
// Ports:
//   CLK, RESET_N        clock, async active-low reset
//   IN, INADDR, WRITE   write data, address, enable
//   OUT1ADDR, OUT2ADDR  read addresses, READ read enable for both ports
//   OUT1, OUT2          registered read data
//   OUT_VALID           one-cycle pulse after each accepted read
//   BUSY                high while the clear sequence runs
module reg_file
  import cpu_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [DATA_W-1:0] IN,
  input  logic [ADDR_W-1:0] INADDR,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] OUT1ADDR,
  input  logic [ADDR_W-1:0] OUT2ADDR,
  input  logic              READ,
  output logic [DATA_W-1:0] OUT1,
  output logic [DATA_W-1:0] OUT2,
  output logic              OUT_VALID,
  output logic              BUSY
);

  logic [NUM_REGS-1:0][DATA_W-1:0] r_regs;
  logic [ADDR_W-1:0]               r_cnt;
  ctrl_state_e                     r_state;
  ctrl_state_e                     w_next_state;
  logic                            r_busy;
  logic                            r_valid;
  logic                            w_wr;
  logic                            w_rd;

  // Port accesses are only honoured once the clear sequence has finished.
  assign w_wr = (r_state == READY) && WRITE;
  assign w_rd = (r_state == READY) && READ;

  // Controller state register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= CLEAR;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Controller next state: leave CLEAR once the last register is zeroed.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      CLEAR:   if (r_cnt == ADDR_W'(NUM_REGS - 1)) w_next_state = READY;
      READY:   w_next_state = READY;
      default: w_next_state = CLEAR;
    endcase
  end

  // Clear counter, busy and valid flags.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_cnt   <= '0;
      r_busy  <= 1'b1;
      r_valid <= 1'b0;
    end else begin
      if (r_state == CLEAR) begin
        r_cnt <= r_cnt + ADDR_W'(1);
      end
      r_busy  <= (w_next_state == CLEAR);
      r_valid <= w_rd;
    end
  end

  // Storage: clear walk takes priority over port writes (which are gated off).
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_regs <= '0;
    end else if (r_state == CLEAR) begin
      r_regs[r_cnt] <= '0;
    end else if (w_wr) begin
      r_regs[INADDR] <= IN;
    end
  end

  reg_read_port u_port1 (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .i_regs    (r_regs),
    .i_addr    (OUT1ADDR),
    .i_read    (w_rd),
    .i_write   (w_wr),
    .i_wr_addr (INADDR),
    .i_wr_data (IN),
    .o_data    (OUT1)
  );

  reg_read_port u_port2 (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .i_regs    (r_regs),
    .i_addr    (OUT2ADDR),
    .i_read    (w_rd),
    .i_write   (w_wr),
    .i_wr_addr (INADDR),
    .i_wr_data (IN),
    .o_data    (OUT2)
  );

  assign OUT_VALID = r_valid;
  assign BUSY      = r_busy;

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vector table, clear/reset
// sequences and randomized traffic against an array-based reference model.
module tb_reg_file;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic [7:0] IN;
  logic [2:0] INADDR;
  logic       WRITE;
  logic [2:0] OUT1ADDR;
  logic [2:0] OUT2ADDR;
  logic       READ;
  logic [7:0] OUT1;
  logic [7:0] OUT2;
  logic       OUT_VALID;
  logic       BUSY;

  reg_file dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .IN        (IN),
    .INADDR    (INADDR),
    .WRITE     (WRITE),
    .OUT1ADDR  (OUT1ADDR),
    .OUT2ADDR  (OUT2ADDR),
    .READ      (READ),
    .OUT1      (OUT1),
    .OUT2      (OUT2),
    .OUT_VALID (OUT_VALID),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // Reference model: register contents plus the expected held outputs.
  logic [7:0] model [8];
  logic [7:0] m_o1, m_o2;
  logic       m_v;

  typedef struct {
    logic       w;
    logic [2:0] wa;
    logic [7:0] wd;
    logic       r;
    logic [2:0] a1;
    logic [2:0] a2;
    logic [7:0] e1;
    logic [7:0] e2;
    logic       ev;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    m_o1 = 8'h00;
    m_o2 = 8'h00;
    m_v  = 1'b0;
  endtask

  // One READY-state cycle: drive, clock, predict from the model.
  task automatic cyc(input logic w, input logic [2:0] wa, input logic [7:0] wd,
                     input logic r, input logic [2:0] a1, input logic [2:0] a2);
    WRITE = w; INADDR = wa; IN = wd;
    READ = r; OUT1ADDR = a1; OUT2ADDR = a2;
    @(posedge CLK); #1;
    if (r) begin
      m_o1 = (BYP && w && wa == a1) ? wd : model[a1];
      m_o2 = (BYP && w && wa == a2) ? wd : model[a2];
      m_v  = 1'b1;
    end else begin
      m_v  = 1'b0;
    end
    if (w) model[wa] = wd;
    WRITE = 1'b0;
    READ  = 1'b0;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_out1"}, 32'(OUT1), 32'(m_o1));
    chk({tag, "_out2"}, 32'(OUT2), 32'(m_o2));
    chk({tag, "_valid"}, 32'(OUT_VALID), 32'(m_v));
    chk({tag, "_busy"}, 32'(BUSY), 32'(0));
  endtask

  // Walks the clear sequence after reset release, checking BUSY each edge.
  task automatic clear_walk(input string tag);
    for (int k = 1; k <= 8; k++) begin
      @(posedge CLK); #1;
      chk({tag, "_busy"}, 32'(BUSY), 32'(k < 8));
    end
  endtask

  initial begin
    RESET_N = 1'b0;
    IN = '0; INADDR = '0; WRITE = 1'b0;
    OUT1ADDR = '0; OUT2ADDR = '0; READ = 1'b0;
    model_reset();

    // Reset held for three cycles.
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_out1", 32'(OUT1), 32'(0));
    chk("rst_out2", 32'(OUT2), 32'(0));
    chk("rst_valid", 32'(OUT_VALID), 32'(0));
    chk("rst_busy", 32'(BUSY), 32'(1));
    RESET_N = 1'b1;

    // Clear sequence with a write and read attempted at edge 2.
    for (int k = 1; k <= 8; k++) begin
      if (k == 2) begin
        WRITE = 1'b1; INADDR = 3'd3; IN = 8'hFF;
        READ = 1'b1; OUT1ADDR = 3'd3; OUT2ADDR = 3'd3;
      end
      @(posedge CLK); #1;
      chk("clr_busy", 32'(BUSY), 32'(k < 8));
      if (k == 2) begin
        chk("clr_valid", 32'(OUT_VALID), 32'(0));
        chk("clr_out1", 32'(OUT1), 32'(0));
      end
      WRITE = 1'b0; READ = 1'b0;
    end

    // First accepted read: r0/r7, then r3 must still be zero.
    cyc(1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 3'd7);
    chk_model("rd07");
    chk("rd07_valid_abs", 32'(OUT_VALID), 32'(1));
    cyc(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 3'd3);
    chk_model("rd3");
    chk("rd3_abs", 32'(OUT1), 32'(0));

    // Directed vectors.
    tbl[0] = '{1'b1, 3'd2, 8'h05, 1'b0, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0};
    tbl[1] = '{1'b1, 3'd5, 8'h0A, 1'b0, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0};
    tbl[2] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 3'd5, 8'h05, 8'h0A, 1'b1};
    tbl[3] = '{1'b1, 3'd2, 8'h09, 1'b0, 3'd0, 3'd0, 8'h05, 8'h0A, 1'b0};
    tbl[4] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 3'd2, 8'h09, 8'h09, 1'b1};
    tbl[5] = '{1'b1, 3'd4, 8'h11, 1'b0, 3'd0, 3'd0, 8'h09, 8'h09, 1'b0};
    tbl[6] = '{1'b1, 3'd4, 8'h22, 1'b1, 3'd4, 3'd5, (BYP ? 8'h22 : 8'h11), 8'h0A, 1'b1};
    tbl[7] = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 3'd4, 8'h22, 8'h22, 1'b1};
    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].w, tbl[i].wa, tbl[i].wd, tbl[i].r, tbl[i].a1, tbl[i].a2);
      chk($sformatf("vec%0d_out1", i), 32'(OUT1), 32'(tbl[i].e1));
      chk($sformatf("vec%0d_out2", i), 32'(OUT2), 32'(tbl[i].e2));
      chk($sformatf("vec%0d_valid", i), 32'(OUT_VALID), 32'(tbl[i].ev));
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      cyc(1'($urandom), 3'($urandom), 8'($urandom), 1'($urandom), 3'($urandom), 3'($urandom));
      chk_model("rnd");
    end

    // Async reset in READY with non-zero outputs: clears without a clock edge.
    cyc(1'b1, 3'd1, 8'h5A, 1'b0, 3'd0, 3'd0);
    cyc(1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 3'd1);
    chk("pre_arst_out1", 32'(OUT1), 32'(8'h5A));
    #1 RESET_N = 1'b0;
    #1;
    chk("arst_out1", 32'(OUT1), 32'(0));
    chk("arst_out2", 32'(OUT2), 32'(0));
    chk("arst_valid", 32'(OUT_VALID), 32'(0));
    chk("arst_busy", 32'(BUSY), 32'(1));
    model_reset();
    repeat (2) @(posedge CLK);
    #1 RESET_N = 1'b1;

    // Reset again at clear step 4; the sequence must restart in full.
    for (int k = 1; k <= 4; k++) begin
      @(posedge CLK); #1;
      chk("mid_busy", 32'(BUSY), 32'(1));
    end
    RESET_N = 1'b0;
    #1;
    chk("mid_out1", 32'(OUT1), 32'(0));
    chk("mid_valid", 32'(OUT_VALID), 32'(0));
    chk("mid_busy_rst", 32'(BUSY), 32'(1));
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    clear_walk("rewalk");

    // Storage must be cleared after the restarted sequence.
    cyc(1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 3'd4);
    chk_model("post_clr");
    chk("post_clr_r1", 32'(OUT1), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
